// File: rtl/fetch_stage_ctrl.sv
// Fetch stage control: owns the PC and the IF/ID register, applies load-use stalls and
// branch redirects, and keeps stall statistics plus sticky debug flags.
module fetch_stage_ctrl #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int                 CNT_W     = 16,
  parameter int                 MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_store,
  input  logic              if_id_write,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic              if_id_valid,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              stall_timeout,
  output logic              ctrl_mismatch
);

  localparam int                RUN_W      = $clog2(MAX_STALL) + 1;
  localparam logic [RUN_W-1:0]  RUN_MAX    = RUN_W'(MAX_STALL);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

  logic [ADDR_W-1:0] pc_q, pc_next, pc_plus4;
  logic [31:0]       instr_next;
  logic [ADDR_W-1:0] pc4_next;
  logic              valid_next;
  logic [CNT_W-1:0]  cycles_next;
  logic [RUN_W-1:0]  run_q, run_next;
  logic              timeout_next, mismatch_next;
  logic              stall_edge;

  assign imem_addr  = pc_q;
  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign stall_edge = !branch_taken && !pc_store;

  // NOTE: every signal gets its hold value first so no path through this block infers a latch.
  always_comb begin
    pc_next       = pc_q;
    instr_next    = if_id_instr;
    pc4_next      = if_id_pc4;
    valid_next    = if_id_valid;
    cycles_next   = stall_cycles;
    run_next      = run_q;
    timeout_next  = stall_timeout;
    mismatch_next = ctrl_mismatch;

    if (branch_taken) begin
      // Redirect wins over both stall controls and flushes the fetched slot.
      pc_next    = branch_target & ALIGN_MASK;
      instr_next = 32'h0;
      pc4_next   = '0;
      valid_next = 1'b0;
      run_next   = '0;
    end else begin
      if (pc_store != if_id_write) mismatch_next = 1'b1;
      if (if_id_write) begin
        instr_next = imem_rdata;
        pc4_next   = pc_plus4;
        valid_next = 1'b1;
      end
      if (pc_store) begin
        pc_next  = pc_plus4;
        run_next = '0;
      end else begin
        if (stall_cycles != CNT_MAX) cycles_next = stall_cycles + 1'b1;
        if (run_q != RUN_MAX)        run_next    = run_q + 1'b1;
        if (run_next == RUN_MAX)     timeout_next = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= PC_INIT;
      if_id_instr   <= 32'h0;
      if_id_pc4     <= '0;
      if_id_valid   <= 1'b0;
      stall_cycles  <= '0;
      run_q         <= '0;
      stall_timeout <= 1'b0;
      ctrl_mismatch <= 1'b0;
    end else begin
      pc_q          <= pc_next;
      if_id_instr   <= instr_next;
      if_id_pc4     <= pc4_next;
      if_id_valid   <= valid_next;
      stall_cycles  <= cycles_next;
      run_q         <= run_next;
      stall_timeout <= timeout_next;
      ctrl_mismatch <= mismatch_next;
    end
  end

  // A stalled edge never moves the PC, so stall_edge implies pc_next == pc_q.
  assert property (@(posedge clk) disable iff (!rst_n) stall_edge |-> (pc_next == pc_q));

endmodule
